// File: rtl/iter_alu.sv
// Registered execute-stage ALU with iterative unsigned MULTU/DIVU and HI/LO registers.
// Build option ALU_SATURATE_EN: clamp ADD/SUB results on signed overflow instead of wrapping.
module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_INIT = (SHW + 1)'(WIDTH);
   localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH - 1) {1'b1}}};
   localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH - 1) {1'b0}}};

   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_NOR = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100, OP_ADDU = 4'b0101, OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111, OP_SLTU = 4'b1000, OP_SLL = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010, OP_SRA = 4'b1011, OP_MULTU = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101, OP_MFHI = 4'b1110, OP_MFLO = 4'b1111;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   // Handshake: start is accepted only in IDLE; busy is high for the WIDTH
   // iteration cycles; done is a one-cycle pulse marking result/flags/hi/lo valid.
   state_t           state_q, state_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0] hw_q, hw_d, lw_q, lw_d, opb_q, opb_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
   logic             zero_q, zero_d, ov_q, ov_d, done_q, done_d;

   logic [WIDTH-1:0] sum, diff, simple_res;
   logic             add_ov, sub_ov, simple_ov;
   logic [SHW-1:0]   shamt;

   always_comb begin
      sum        = a + b;
      diff       = a - b;
      add_ov     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      sub_ov     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      shamt      = b[SHW-1:0];
      simple_res = '0;
      simple_ov  = 1'b0;
      case (op)
         OP_AND:  simple_res = a & b;
         OP_OR:   simple_res = a | b;
         OP_NOR:  simple_res = ~(a | b);
         OP_ADD: begin
            simple_res = sum;
            simple_ov  = add_ov;
`ifdef ALU_SATURATE_EN
            if (add_ov) simple_res = a[WIDTH-1] ? S_MIN : S_MAX;
`endif
         end
         OP_ADDU: simple_res = sum;
         OP_SUB: begin
            simple_res = diff;
            simple_ov  = sub_ov;
`ifdef ALU_SATURATE_EN
            if (sub_ov) simple_res = a[WIDTH-1] ? S_MIN : S_MAX;
`endif
         end
         OP_SLT:  simple_res = {{(WIDTH - 1) {1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: simple_res = {{(WIDTH - 1) {1'b0}}, (a < b)};
         OP_SLL:  simple_res = a << shamt;
         OP_SRL:  simple_res = a >> shamt;
         OP_SRA:  simple_res = $signed(a) >>> shamt;
         OP_MFHI: simple_res = hi_q;
         OP_MFLO: simple_res = lo_q;
         default: simple_res = '0;
      endcase
   end

   // One iteration: hw/lw hold {acc, multiplier} for MULTU and {remainder, dividend} for DIVU.
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic [WIDTH-1:0] step_hw, step_lw;

   always_comb begin
      mul_sum  = lw_q[0] ? ({1'b0, hw_q} + {1'b0, opb_q}) : {1'b0, hw_q};
      div_sh   = {hw_q, lw_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, opb_q};
      if (is_div_q) begin
         if (!div_diff[WIDTH]) begin
            step_hw = div_diff[WIDTH-1:0];
            step_lw = {lw_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hw = div_sh[WIDTH-1:0];
            step_lw = {lw_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hw = mul_sum[WIDTH:1];
         step_lw = {mul_sum[0], lw_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hw_d     = hw_q;
      lw_d     = lw_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      zero_d   = zero_q;
      ov_d     = ov_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (op == OP_MULTU || op == OP_DIVU) begin
                  state_d  = RUN;
                  cnt_d    = CNT_INIT;
                  opb_d    = b;
                  is_div_d = (op == OP_DIVU);
                  hw_d     = '0;
                  lw_d     = a;
               end else begin
                  result_d = simple_res;
                  zero_d   = (simple_res == '0);
                  ov_d     = simple_ov;
                  done_d   = 1'b1;
               end
            end
         end
         RUN: begin
            hw_d  = step_hw;
            lw_d  = step_lw;
            cnt_d = cnt_q - 1'b1;
            // The last step loads hi/lo/result so they are visible during FIN.
            if (cnt_q == 1) begin
               state_d  = FIN;
               hi_d     = step_hw;
               lo_d     = step_lw;
               result_d = step_lw;
               zero_d   = (step_lw == '0);
               ov_d     = 1'b0;
               done_d   = 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hw_q     <= '0;
         lw_q     <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ov_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hw_q     <= hw_d;
         lw_q     <= lw_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ov_q     <= ov_d;
         done_q   <= done_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ov_q;
   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu: the driver pushes expected responses, a negedge monitor
// pops and compares them on every done pulse, including latency and busy length.
module tb_iter_alu;
   localparam int W = 32;
   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_RSV = 4'b0010, OP_NOR = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100, OP_ADDU = 4'b0101, OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111, OP_SLTU = 4'b1000, OP_SLL = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010, OP_SRA = 4'b1011, OP_MULTU = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101, OP_MFHI = 4'b1110, OP_MFLO = 4'b1111;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [3:0]   op;
   logic [W-1:0] a, b, result, hi, lo;
   logic         zero, overflow, busy, done;

   iter_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .result(result), .zero(zero), .overflow(overflow), .busy(busy),
      .done(done), .hi(hi), .lo(lo)
   );

   // clock/reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_hi_q[$];
   logic [W-1:0] exp_lo_q[$];
   logic [1:0]   exp_flag_q[$];
   int           exp_cyc_q[$];
   int           exp_busy_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           busy_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
               logic [1:0] fl;
               fl = exp_flag_q.pop_front();
               check("result", result, exp_q.pop_front());
               check("zero", zero, fl[1]);
               check("overflow", overflow, fl[0]);
               check("hi", hi, exp_hi_q.pop_front());
               check("lo", lo, exp_lo_q.pop_front());
               check("latency_cycle", cyc, exp_cyc_q.pop_front());
               check("busy_cycles", busy_cnt, exp_busy_q.pop_front());
            end
            busy_cnt = 0;
         end
      end
   end

   // driver tasks: called #1 after a rising edge
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ez, input logic eo,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input bit long_op);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      exp_q.push_back(er);
      exp_flag_q.push_back({ez, eo});
      exp_hi_q.push_back(eh);
      exp_lo_q.push_back(el);
      exp_cyc_q.push_back(cyc + 1 + (long_op ? W : 0));
      exp_busy_q.push_back(long_op ? W : 0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      @(posedge clk); #1;
      check("rst_result", result, 0);
      check("rst_zero", zero, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);

`ifdef ALU_SATURATE_EN
      issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF, 0, 1, 0, 0, 0);
`else
      issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 0, 0);
`endif
      idle(2);
      // back-to-back simple ops
      issue(OP_SUB,  32'd5,        32'd5,        32'h0,        1, 0, 0, 0, 0);
      issue(OP_ADDU, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 0, 0);
      issue(OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 0, 0);
      issue(OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 0, 0);
      issue(OP_SRA,  32'h80000000, 32'd4,        32'hF8000000, 0, 0, 0, 0, 0);
      issue(OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 0, 0, 0, 0, 0);
      issue(OP_AND,  32'hF0F000FF, 32'h0FF0FF0F, 32'h00F0000F, 0, 0, 0, 0, 0);
      issue(OP_OR,   32'hF0F000FF, 32'h0FF0FF0F, 32'hFFF0FFFF, 0, 0, 0, 0, 0);
      issue(OP_NOR,  32'hF0F000FF, 32'h0FF0FF0F, 32'h000F0000, 0, 0, 0, 0, 0);
      issue(OP_SLL,  32'h1,        32'd31,       32'h80000000, 0, 0, 0, 0, 0);
      issue(OP_RSV,  32'h1234,     32'h5678,     32'h0,        1, 0, 0, 0, 0);
`ifdef ALU_SATURATE_EN
      issue(OP_SUB,  32'h80000000, 32'h1,        32'h80000000, 0, 1, 0, 0, 0);
      issue(OP_ADD,  32'h80000000, 32'h80000000, 32'h80000000, 0, 1, 0, 0, 0);
`else
      issue(OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 0, 0, 0);
      issue(OP_ADD,  32'h80000000, 32'h80000000, 32'h0,        1, 1, 0, 0, 0);
`endif
      idle(2);

      issue(OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFE, 1);
      idle(W + 2);
      issue(OP_MFHI, 32'h0, 32'h0, 32'h1,        0, 0, 32'h1, 32'hFFFFFFFE, 0);
      issue(OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFE, 0);
      idle(1);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 0, 0, 32'd2, 32'd14, 1);
      idle(W + 2);
      issue(OP_DIVU, 32'h1234, 32'h0, 32'hFFFFFFFF, 0, 0, 32'h1234, 32'hFFFFFFFF, 1);
      idle(W + 2);

      // start during busy is dropped: only the MULTU completes
      issue(OP_MULTU, 32'd3, 32'd5, 32'd15, 0, 0, 32'h0, 32'd15, 1);
      idle(5);
      start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      idle(W + 2);

      // reset in the middle of a MULTU aborts it with no done
      start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      @(posedge clk); #1;
      idle(8);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      rst = 1'b0;
      idle(W + 5);

      issue(OP_MFLO, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
      idle(W + 5);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
